// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  // Default data/address width of the SRAM bus.
  localparam int ARB_DATAWIDTH = 16;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  // Requester identity, used both for the current grant and for rotation.
  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_VGA = 1'b1
  } gnt_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundles the CPU port, VGA port and SRAM pins seen by the arbiter.
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = ARB_DATAWIDTH
);
  // CPU data port
  logic                 cpu_req;
  logic                 cpu_we;
  logic [DATAWIDTH-1:0] cpu_addr;
  logic [DATAWIDTH-1:0] cpu_wdata;
  logic                 cpu_ack;
  logic [DATAWIDTH-1:0] cpu_rdata;
  // VGA pixel fetch port (read only)
  logic                 vga_req;
  logic [DATAWIDTH-1:0] vga_addr;
  logic                 vga_ack;
  logic [DATAWIDTH-1:0] vga_rdata;
  // Status
  logic                 busy;
  // External asynchronous SRAM, strobes active-low
  logic                 sram_ce;
  logic                 sram_oe;
  logic                 sram_we;
  logic [DATAWIDTH-1:0] sram_addr;
  logic [DATAWIDTH-1:0] sram_dout;
  logic [DATAWIDTH-1:0] sram_din;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, sram_din,
    output cpu_ack, cpu_rdata, vga_ack, vga_rdata, busy,
           sram_ce, sram_oe, sram_we, sram_addr, sram_dout
  );

  // Requester / SRAM model side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, sram_din,
    input  cpu_ack, cpu_rdata, vga_ack, vga_rdata, busy,
           sram_ce, sram_oe, sram_we, sram_addr, sram_dout
  );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way combinational grant: lone requester wins; ties go to VGA in
// priority mode, otherwise to the port that was not granted last.
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic vga_req,
  input  gnt_e last_gnt,
  input  logic vga_priority,
  output logic gnt_valid,
  output gnt_e gnt
);

  // Resolve the winner among the currently asserted requests.
  always_comb begin
    gnt_valid = cpu_req | vga_req;
    gnt       = GNT_CPU;
    if (cpu_req && vga_req) begin
      if (vga_priority || (last_gnt == GNT_CPU)) begin
        gnt = GNT_VGA;
      end else begin
        gnt = GNT_CPU;
      end
    end else if (vga_req) begin
      gnt = GNT_VGA;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU and VGA ports. Each access
// is a fixed-length strobe cycle IDLE -> ACCESS (WAIT_CYC+1) -> DONE, with
// the strobes decoded from registered state so they switch only on edges.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DATAWIDTH    = ARB_DATAWIDTH,
  parameter int WAIT_CYC     = 1,
  parameter bit VGA_PRIORITY = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYC);

  arb_state_e           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  // gnt_q only changes when a grant is issued, so it doubles as last_gnt.
  gnt_e                 gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [DATAWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATAWIDTH-1:0] vga_rdata_q, vga_rdata_d;

  logic arb_valid;
  gnt_e arb_gnt;

  rr_arb2 u_rr_arb2 (
    .cpu_req      (bus.cpu_req),
    .vga_req      (bus.vga_req),
    .last_gnt     (gnt_q),
    .vga_priority (VGA_PRIORITY),
    .gnt_valid    (arb_valid),
    .gnt          (arb_gnt)
  );

  // Next-state and datapath-load logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          cnt_d   = WAIT_LOAD;
          wdata_d = bus.cpu_wdata;
          if (arb_gnt == GNT_VGA) begin
            addr_d = bus.vga_addr;
            we_d   = 1'b0;
          end else begin
            addr_d = bus.cpu_addr;
            we_d   = bus.cpu_we;
          end
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == 3'd0) begin
          // Read data is taken on the edge that ends the strobe.
          if (!we_q) begin
            if (gnt_q == GNT_VGA) vga_rdata_d = bus.sram_din;
            else                  cpu_rdata_d = bus.sram_din;
          end
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= 3'd0;
      gnt_q       <= GNT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
    end
  end

  assign bus.sram_ce   = ~(state_q == ARB_ACCESS);
  assign bus.sram_oe   = ~((state_q == ARB_ACCESS) && !we_q);
  assign bus.sram_we   = ~((state_q == ARB_ACCESS) && we_q);
  assign bus.sram_addr = addr_q;
  assign bus.sram_dout = wdata_q;
  assign bus.busy      = (state_q != ARB_IDLE);
  assign bus.cpu_ack   = (state_q == ARB_DONE) && (gnt_q == GNT_CPU);
  assign bus.vga_ack   = (state_q == ARB_DONE) && (gnt_q == GNT_VGA);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vga_rdata = vga_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance A (WAIT_CYC=1, round-robin) is tracked
// every cycle by a transaction-level scheduling model; instance B
// (WAIT_CYC=0, VGA priority) gets directed priority and back-to-back tests.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int WA = 1;

  logic clk;
  logic rst_n;

  sram_arbiter_if #(.DATAWIDTH(16)) ifa ();
  sram_arbiter_if #(.DATAWIDTH(16)) ifb ();

  sram_arbiter #(.DATAWIDTH(16), .WAIT_CYC(WA), .VGA_PRIORITY(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  sram_arbiter #(.DATAWIDTH(16), .WAIT_CYC(0), .VGA_PRIORITY(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SRAM contents (stub for A, reference copy for model)
  logic [15:0] sram_mem [logic [15:0]];
  logic [15:0] ref_mem  [logic [15:0]];

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] stub_rd(input logic [15:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Asynchronous SRAM stubs, evaluated mid-cycle.
  initial begin
    sram_mem[16'h0123] = 16'hBEEF;
    forever begin
      @(negedge clk);
      if (ifa.sram_ce === 1'b0 && ifa.sram_we === 1'b0) sram_mem[ifa.sram_addr] = ifa.sram_dout;
      ifa.sram_din = stub_rd(ifa.sram_addr);
      ifb.sram_din = ifb.sram_addr ^ 16'hC3C3;
    end
  end

  // ---------------- Transaction-level reference model for instance A
  int          cyc = 0;
  bit          m_act = 0;
  int          m_s = 0;
  int          m_free = 0;
  bit          m_vga = 0;
  bit          m_we = 0;
  bit          m_last_vga = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] e_cpu_rd = '0;
  logic [15:0] e_vga_rd = '0;
  logic [15:0] e_addr = '0;
  logic [15:0] e_dout = '0;

  initial begin
    ref_mem[16'h0123] = 16'hBEEF;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_act = 0; m_last_vga = 0; m_free = cyc + 1;
        e_cpu_rd = '0; e_vga_rd = '0; e_addr = '0; e_dout = '0;
      end else begin
        if (m_act && cyc == m_s + WA + 1 && !m_we) begin
          if (m_vga) e_vga_rd = ref_rd(m_addr);
          else       e_cpu_rd = ref_rd(m_addr);
        end
        if (m_act && cyc == m_s + WA + 2) m_act = 0;
        if (cyc >= m_free && (ifa.cpu_req || ifa.vga_req)) begin
          if (ifa.cpu_req && ifa.vga_req) m_vga = !m_last_vga;
          else                            m_vga = ifa.vga_req;
          m_act = 1; m_s = cyc; m_free = cyc + WA + 3; m_last_vga = m_vga;
          m_we   = m_vga ? 1'b0 : ifa.cpu_we;
          m_addr = m_vga ? ifa.vga_addr : ifa.cpu_addr;
          e_addr = m_addr;
          if (m_we) begin
            ref_mem[m_addr] = ifa.cpu_wdata;
            e_dout = ifa.cpu_wdata;
          end
        end
      end
    end
  end

  // Per-cycle comparison of instance A against the model.
  bit chk_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit acc, done;
        acc  = m_act && (cyc >= m_s) && (cyc <= m_s + WA);
        done = m_act && (cyc == m_s + WA + 1);
        chk("m_ce",   ifa.sram_ce, !acc);
        chk("m_oe",   ifa.sram_oe, !(acc && !m_we));
        chk("m_we",   ifa.sram_we, !(acc && m_we));
        chk("m_busy", ifa.busy, acc || done);
        chk("m_cpu_ack", ifa.cpu_ack, done && !m_vga);
        chk("m_vga_ack", ifa.vga_ack, done && m_vga);
        chk("m_cpu_rdata", ifa.cpu_rdata, e_cpu_rd);
        chk("m_vga_rdata", ifa.vga_rdata, e_vga_rd);
        chk("m_addr", ifa.sram_addr, e_addr);
        if ((acc || done) && m_we) chk("m_dout", ifa.sram_dout, e_dout);
      end
    end
  end

  task automatic new_cpu_req();
    ifa.cpu_req   = 1'b1;
    ifa.cpu_we    = 1'($urandom_range(1, 0));
    ifa.cpu_addr  = 16'($urandom_range(31, 0));
    ifa.cpu_wdata = 16'($urandom);
  endtask

  task automatic new_vga_req();
    ifa.vga_req  = 1'b1;
    ifa.vga_addr = 16'($urandom_range(31, 0));
  endtask

  // ---------------- Directed and random stimulus
  initial begin
    int n_ce, n_oe, n_we, n_bad, n_ack, lat, got, cwait, vwait, t1, t2;
    logic [15:0] rd, rd1, rd2;
    logic order [4];

    rst_n = 1'b0;
    ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
    ifa.vga_req = 0; ifa.vga_addr = '0;
    ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
    ifb.vga_req = 0; ifb.vga_addr = '0;
    for (int i = 0; i < 4; i++) order[i] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ce", ifa.sram_ce, 1); chk("rst_oe", ifa.sram_oe, 1); chk("rst_we", ifa.sram_we, 1);
    chk("rst_addr", ifa.sram_addr, 0); chk("rst_dout", ifa.sram_dout, 0);
    chk("rst_cpu_rdata", ifa.cpu_rdata, 0); chk("rst_vga_rdata", ifa.vga_rdata, 0);
    chk("rst_cpu_ack", ifa.cpu_ack, 0); chk("rst_vga_ack", ifa.vga_ack, 0);
    chk("rst_busy", ifa.busy, 0); chk("rst_b_busy", ifb.busy, 0);
    rst_n = 1'b1;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // T1: CPU read of 0x0123
    ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 16'h0123;
    n_ce = 0; n_oe = 0; lat = 0; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!ifa.sram_ce) n_ce++;
      if (!ifa.sram_oe) n_oe++;
      if (ifa.cpu_ack && lat == 0) begin lat = i; rd = ifa.cpu_rdata; ifa.cpu_req = 0; end
    end
    chk("t1_ce_width", n_ce, 2); chk("t1_oe_width", n_oe, 2);
    chk("t1_ack_latency", lat, 3); chk("t1_rdata", rd, 16'hBEEF);

    // T2: CPU write 0x55AA to 0x4000
    ifa.cpu_req = 1; ifa.cpu_we = 1; ifa.cpu_addr = 16'h4000; ifa.cpu_wdata = 16'h55AA;
    n_we = 0; n_oe = 0; n_bad = 0; n_ack = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!ifa.sram_we) n_we++;
      if (!ifa.sram_we && !ifa.sram_oe) n_oe++;
      if ((!ifa.sram_we || ifa.cpu_ack) &&
          (ifa.sram_addr != 16'h4000 || ifa.sram_dout != 16'h55AA)) n_bad++;
      if (ifa.cpu_ack) begin n_ack++; ifa.cpu_req = 0; end
    end
    chk("t2_we_width", n_we, 2); chk("t2_oe_during_we", n_oe, 0);
    chk("t2_addr_data_stable", n_bad, 0); chk("t2_ack_count", n_ack, 1);
    chk("t2_mem", stub_rd(16'h4000), 16'h55AA);

    // T3: both requesting continuously, round-robin
    ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 16'h0010;
    ifa.vga_req = 1; ifa.vga_addr = 16'h0020;
    n_ack = 0;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      @(negedge clk);
      chk("t3_single_ack", ifa.cpu_ack & ifa.vga_ack, 0);
      if (ifa.cpu_ack || ifa.vga_ack) begin order[n_ack] = ifa.vga_ack; n_ack++; end
    end
    ifa.cpu_req = 0; ifa.vga_req = 0;
    chk("t3_ack_count", n_ack, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_grant%0d_is_vga", k), order[k], (k % 2) == 0);
    repeat (4) @(negedge clk);

    // T4: reset in the second ACCESS cycle of a VGA read
    ifa.vga_req = 1; ifa.vga_addr = 16'h0123;
    repeat (2) @(negedge clk);
    chk("t4_in_access", ifa.sram_ce, 0);
    rst_n = 0; ifa.vga_req = 0;
    @(negedge clk);
    chk("t4_ce", ifa.sram_ce, 1); chk("t4_oe", ifa.sram_oe, 1); chk("t4_we", ifa.sram_we, 1);
    chk("t4_busy", ifa.busy, 0); chk("t4_vga_ack", ifa.vga_ack, 0); chk("t4_vga_rdata", ifa.vga_rdata, 0);
    rst_n = 1;
    repeat (4) begin @(negedge clk); chk("t4_no_late_ack", ifa.vga_ack, 0); end
    ifa.vga_req = 1;
    got = 0; rd = '0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (ifa.vga_ack) begin got = 1; rd = ifa.vga_rdata; ifa.vga_req = 0; end
    end
    ifa.vga_req = 0;
    chk("t4_reissue_ack", got, 1); chk("t4_reissue_rdata", rd, 16'hBEEF);
    repeat (3) @(negedge clk);

    // Random traffic on A, checked cycle by cycle by the model
    cwait = 0; vwait = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (ifa.cpu_req) begin
        if (ifa.cpu_ack) begin
          cwait = 0;
          if ($urandom_range(1, 0) == 1) new_cpu_req(); else ifa.cpu_req = 0;
        end else begin
          cwait++;
          if (cwait > 16) begin chk("rnd_cpu_wait", cwait, 16); ifa.cpu_req = 0; cwait = 0; end
        end
      end else if ($urandom_range(3, 0) == 0) new_cpu_req();
      if (ifa.vga_req) begin
        if (ifa.vga_ack) begin
          vwait = 0;
          if ($urandom_range(1, 0) == 1) new_vga_req(); else ifa.vga_req = 0;
        end else begin
          vwait++;
          if (vwait > 16) begin chk("rnd_vga_wait", vwait, 16); ifa.vga_req = 0; vwait = 0; end
        end
      end else if ($urandom_range(3, 0) == 0) new_vga_req();
    end
    @(negedge clk);
    ifa.cpu_req = 0; ifa.vga_req = 0;
    repeat (6) @(negedge clk);

    // B1: VGA priority with both requesting
    ifb.cpu_req = 1; ifb.cpu_we = 0; ifb.cpu_addr = 16'h0033;
    ifb.vga_req = 1; ifb.vga_addr = 16'h0040;
    n_ack = 0; got = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ifb.vga_ack) n_ack++;
      if (ifb.cpu_ack) got++;
    end
    chk("b1_vga_acks", n_ack, 7); chk("b1_cpu_acks", got, 0);
    chk("b1_vga_rdata", ifb.vga_rdata, 16'h0040 ^ 16'hC3C3);
    ifb.vga_req = 0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (ifb.cpu_ack) begin got = 1; ifb.cpu_req = 0; end
    end
    ifb.cpu_req = 0;
    chk("b1_cpu_served_after", got, 1);
    repeat (3) @(negedge clk);

    // B2: back-to-back CPU reads with WAIT_CYC=0
    ifb.cpu_req = 1; ifb.cpu_addr = 16'h0001;
    t1 = -1; t2 = -1; rd1 = '0; rd2 = '0;
    for (int i = 1; i <= 15 && t2 < 0; i++) begin
      @(negedge clk);
      if (ifb.cpu_ack) begin
        if (t1 < 0) begin t1 = i; rd1 = ifb.cpu_rdata; ifb.cpu_addr = 16'h0002; end
        else begin t2 = i; rd2 = ifb.cpu_rdata; ifb.cpu_req = 0; end
      end
    end
    ifb.cpu_req = 0;
    chk("b2_first_latency", t1, 2);
    chk("b2_ack_spacing", t2 - t1, 3);
    chk("b2_rdata1", rd1, 16'h0001 ^ 16'hC3C3);
    chk("b2_rdata2", rd2, 16'h0002 ^ 16'hC3C3);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
